// File: rtl/frame_sync.sv
// frame_sync: hard-decision frame synchronizer that follows the bit synchronizer.
// It hunts for a 16-bit sync word in either polarity and confirms it over
// consecutive frames. Once locked it emits polarity-corrected payload bytes,
// with a flywheel that tolerates missed sync words.
module frame_sync #(
  parameter logic [15:0] SYNC_WORD     = 16'hEB90,
  parameter int          PAYLOAD_BYTES = 32,
  parameter int          ERR_TOL       = 1,
  parameter int          CONFIRM       = 2,
  parameter int          FLYWHEEL      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] datain,
  input  logic       bit_sync,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       sof,
  output logic       lock,
  output logic       inverted
);

  localparam int DATA_W     = 6;
  localparam int FRAME_BITS = 16 + 8 * PAYLOAD_BYTES;
  localparam int PAY_BITS   = 8 * PAYLOAD_BYTES;
  localparam int BC_W       = $clog2(FRAME_BITS);
  localparam int CNT_W      = 4;

  localparam logic [BC_W-1:0]  BC_LAST     = BC_W'(FRAME_BITS - 1);
  localparam logic [BC_W-1:0]  BC_PAY_LAST = BC_W'(PAY_BITS - 1);
  localparam logic [CNT_W-1:0] CONFIRM_C   = CNT_W'(CONFIRM);
  localparam logic [CNT_W-1:0] FLYWHEEL_C  = CNT_W'(FLYWHEEL);
  localparam logic [4:0]       ERR_TOL_C   = 5'(ERR_TOL);

  typedef enum logic [1:0] {HUNT, CHECK, LOCK, FLY} state_t;

  // Number of set bits in a 16-bit word (Hamming weight).
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  logic signed [DATA_W-1:0] sample_s;
  logic                     bs_q;
  logic                     edge_d, edge_q;
  logic                     bit_d;
  logic [15:0]              sr_q;

  state_t                   state_q;
  logic [BC_W-1:0]          bc_q, bc_d;
  logic [CNT_W-1:0]         confirm_q, miss_q;
  logic [6:0]               byte_q;
  logic [7:0]               dout_q;
  logic                     dout_valid_q, sof_q, lock_q, inverted_q;

  logic [4:0]               dist_p, dist_n;
  logic                     sync_hit, at_check, in_pay, pbit;

  // Stage 0: bit-edge detection and hard decision (non-negative sample means 1).
  assign sample_s = datain;
  assign edge_d   = bit_sync & ~bs_q;
  assign bit_d    = (sample_s >= 6'sd0);

  // Shift decided bits into the sync search register on each bit edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bs_q   <= 1'b0;
      edge_q <= 1'b0;
      sr_q   <= '0;
    end else begin
      bs_q   <= bit_sync;
      edge_q <= edge_d;
      if (edge_d) sr_q <= {sr_q[14:0], bit_d};
    end
  end

  // Stage 1: sync compare and frame bookkeeping, evaluated the cycle after an edge.
  assign dist_p   = popcount16(sr_q ^ SYNC_WORD);
  assign dist_n   = popcount16(sr_q ^ ~SYNC_WORD);
  assign sync_hit = inverted_q ? (dist_n <= ERR_TOL_C) : (dist_p <= ERR_TOL_C);
  assign at_check = (bc_q == BC_LAST);
  assign in_pay   = (bc_q <= BC_PAY_LAST);
  assign bc_d     = at_check ? '0 : bc_q + 1'b1;
  assign pbit     = sr_q[0] ^ inverted_q;

  // Frame state machine with registered byte, strobe and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= HUNT;
      bc_q         <= '0;
      confirm_q    <= '0;
      miss_q       <= '0;
      byte_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      lock_q       <= 1'b0;
      inverted_q   <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      if (edge_q) begin
        case (state_q)
          HUNT: begin
            // Exact match only; the true polarity wins if both could match.
            if (dist_p == 5'd0) begin
              state_q    <= CHECK;
              inverted_q <= 1'b0;
              bc_q       <= '0;
              confirm_q  <= CNT_W'(1);
            end else if (dist_n == 5'd0) begin
              state_q    <= CHECK;
              inverted_q <= 1'b1;
              bc_q       <= '0;
              confirm_q  <= CNT_W'(1);
            end
          end
          CHECK: begin
            bc_q <= bc_d;
            if (at_check) begin
              if (sync_hit) begin
                confirm_q <= confirm_q + 1'b1;
                if (confirm_q + 1'b1 >= CONFIRM_C) begin
                  state_q <= LOCK;
                  lock_q  <= 1'b1;
                  miss_q  <= '0;
                end
              end else begin
                state_q    <= HUNT;
                inverted_q <= 1'b0;
                confirm_q  <= '0;
                bc_q       <= '0;
              end
            end
          end
          LOCK, FLY: begin
            bc_q <= bc_d;
            // Payload assembly; a byte completes on every 8th payload bit.
            if (in_pay) begin
              byte_q <= {byte_q[5:0], pbit};
              if (bc_q[2:0] == 3'd7) begin
                dout_q       <= {byte_q, pbit};
                dout_valid_q <= 1'b1;
                sof_q        <= (bc_q == BC_W'(7));
              end
            end
            // Flywheel: tolerate isolated sync misses before giving up lock.
            if (at_check) begin
              if (sync_hit) begin
                state_q <= LOCK;
                miss_q  <= '0;
              end else if (miss_q + 1'b1 >= FLYWHEEL_C) begin
                state_q    <= HUNT;
                lock_q     <= 1'b0;
                inverted_q <= 1'b0;
                miss_q     <= '0;
                confirm_q  <= '0;
                bc_q       <= '0;
              end else begin
                state_q <= FLY;
                miss_q  <= miss_q + 1'b1;
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  // Stage 2: registered outputs.
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sof        = sof_q;
  assign lock       = lock_q;
  assign inverted   = inverted_q;

endmodule

// File: tb/tb_frame_sync.sv
// Scoreboard bench for frame_sync: stimulus pushes expected payload bytes,
// an independent monitor pops and compares whenever dout_valid is seen.
module tb_frame_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] datain;
  logic       bit_sync;
  logic [7:0] dout;
  logic       dout_valid, sof, lock, inverted;

  int checks = 0;
  int errors = 0;

  // Expected entries: {byte, sof, inverted}
  logic [9:0] sb[$];
  logic [9:0] exp_e;

  frame_sync dut (
    .clk        (clk),
    .rst        (rst),
    .datain     (datain),
    .bit_sync   (bit_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sof        (sof),
    .lock       (lock),
    .inverted   (inverted)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare every presented byte against the scoreboard head.
  always begin
    @(posedge clk);
    #1;
    if (rst === 1'b1) begin
      if (dout_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got dout=%h sof=%b, required no output", dout, sof);
        end else begin
          exp_e = sb.pop_front();
          check_val("byte{dout,sof,inv}", 32'({dout, sof, inverted}), 32'(exp_e));
        end
      end else if (sof === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL stray_sof: got sof=1 without dout_valid, required sof=0");
      end
    end
  end

  // mode 0: +/-20, mode 1: negated stream, mode 2: boundary samples 0 / -1
  task automatic send_bit(input logic b, input int mode, input bit chk,
                          input logic lk_pre, input logic lk_post, input string nm);
    logic [5:0] s;
    case (mode)
      1:       s = b ? 6'h2C : 6'd20;
      2:       s = b ? 6'd0  : 6'h3F;
      default: s = b ? 6'd20 : 6'h2C;
    endcase
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (chk && i == 1) check_val({nm, "_lock_N+1"}, 32'(lock), 32'(lk_pre));
      if (chk && i == 2) check_val({nm, "_lock_N+2"}, 32'(lock), 32'(lk_post));
      datain   = s;
      bit_sync = (i < 4);
    end
  endtask

  task automatic send_word(input logic [15:0] w, input int mode,
                           input logic lk_pre, input logic lk_post, input string nm);
    for (int i = 15; i >= 0; i--)
      send_bit(w[i], mode, (i == 0), lk_pre, lk_post, nm);
  endtask

  task automatic send_byte(input logic [7:0] b, input int mode);
    for (int i = 7; i >= 0; i--) send_bit(b[i], mode, 1'b0, 1'b0, 1'b0, "");
  endtask

  task automatic send_frame(input logic [15:0] sw, input bit push, input int mode,
                            input logic inv, input logic lk_pre, input logic lk_post,
                            input string nm);
    if (push)
      for (int k = 0; k < 32; k++) sb.push_back({8'(k), (k == 0), inv});
    send_word(sw, mode, lk_pre, lk_post, nm);
    for (int k = 0; k < 32; k++) send_byte(8'(k), mode);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst      = 1'b0;
    bit_sync = 1'b0;
    datain   = 6'd0;
    repeat (3) @(negedge clk);
    check_val({nm, "_reset_outputs"}, 32'({dout, dout_valid, sof, lock, inverted}), 32'd0);
    sb.delete();
    rst = 1'b1;
  endtask

  task automatic finish_test(input string nm);
    repeat (40) @(negedge clk);
    check_val({nm, "_all_bytes_seen"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    bit_sync = 1'b0;
    datain   = 6'd0;

    // A: clean frames with boundary-valued samples (0 -> 1, -1 -> 0)
    do_reset("A");
    send_frame(16'hEB90, 1'b0, 2, 1'b0, 1'b0, 1'b0, "A_sync1");
    send_frame(16'hEB90, 1'b1, 2, 1'b0, 1'b0, 1'b1, "A_sync2");
    send_frame(16'hEB90, 1'b1, 2, 1'b0, 1'b1, 1'b1, "A_sync3");
    send_frame(16'hEB90, 1'b1, 2, 1'b0, 1'b1, 1'b1, "A_sync4");
    finish_test("A");
    check_val("A_inverted", 32'(inverted), 32'd0);

    // B: negated stream, sync seen as 146F
    do_reset("B");
    send_frame(16'hEB90, 1'b0, 1, 1'b1, 1'b0, 1'b0, "B_sync1");
    send_frame(16'hEB90, 1'b1, 1, 1'b1, 1'b0, 1'b1, "B_sync2");
    send_frame(16'hEB90, 1'b1, 1, 1'b1, 1'b1, 1'b1, "B_sync3");
    finish_test("B");
    check_val("B_inverted", 32'(inverted), 32'd1);

    // C: single bit error in sync word 3 is still a hit
    do_reset("C");
    send_frame(16'hEB90, 1'b0, 0, 1'b0, 1'b0, 1'b0, "C_sync1");
    send_frame(16'hEB90, 1'b1, 0, 1'b0, 1'b0, 1'b1, "C_sync2");
    send_frame(16'hEB91, 1'b1, 0, 1'b0, 1'b1, 1'b1, "C_sync3");
    send_frame(16'hEB90, 1'b1, 0, 1'b0, 1'b1, 1'b1, "C_sync4");
    finish_test("C");

    // D: three missing sync words drop lock, then reacquire
    do_reset("D");
    send_frame(16'hEB90, 1'b0, 0, 1'b0, 1'b0, 1'b0, "D_sync1");
    send_frame(16'hEB90, 1'b1, 0, 1'b0, 1'b0, 1'b1, "D_sync2");
    send_frame(16'h0000, 1'b1, 0, 1'b0, 1'b1, 1'b1, "D_miss1");
    send_frame(16'h0000, 1'b1, 0, 1'b0, 1'b1, 1'b1, "D_miss2");
    send_frame(16'h0000, 1'b0, 0, 1'b0, 1'b1, 1'b0, "D_miss3");
    send_frame(16'hEB90, 1'b0, 0, 1'b0, 1'b0, 1'b0, "D_sync6");
    send_frame(16'hEB90, 1'b1, 0, 1'b0, 1'b0, 1'b1, "D_sync7");
    finish_test("D");

    // E: sync pattern embedded in data while hunting: false CHECK, no output
    do_reset("E");
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_word(16'hEB90, 0, 1'b0, 1'b0, "E_false_sync");
    for (int k = 0; k < 33; k++) send_byte(8'h00, 0);
    send_word({8'h00, 8'h00} >> 8, 0, 1'b0, 1'b0, "E_false_check_pad");
    send_frame(16'hEB90, 1'b0, 0, 1'b0, 1'b0, 1'b0, "E_sync1");
    send_frame(16'hEB90, 1'b1, 0, 1'b0, 1'b0, 1'b1, "E_sync2");
    finish_test("E");

    // F: asynchronous reset mid-byte while locked
    do_reset("F");
    send_frame(16'hEB90, 1'b0, 0, 1'b0, 1'b0, 1'b0, "F_sync1");
    send_frame(16'hEB90, 1'b1, 0, 1'b0, 1'b0, 1'b1, "F_sync2");
    for (int k = 0; k < 5; k++) sb.push_back({8'(k), (k == 0), 1'b0});
    send_word(16'hEB90, 0, 1'b1, 1'b1, "F_sync3");
    for (int k = 0; k < 5; k++) send_byte(8'(k), 0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 0, 1'b0, 1'b0, 1'b0, "");
    check_val("F_dout_hold", 32'(dout), 32'h04);
    check_val("F_sb_before_rst", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_val("F_async_clear", 32'({dout, dout_valid, sof, lock, inverted}), 32'd0);
    repeat (4) @(negedge clk);
    bit_sync = 1'b0;
    rst      = 1'b1;
    send_frame(16'hEB90, 1'b0, 0, 1'b0, 1'b0, 1'b0, "F_relock1");
    send_frame(16'hEB90, 1'b1, 0, 1'b0, 1'b0, 1'b1, "F_relock2");
    finish_test("F");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
